// File: rtl/i2c_pkg.sv
// Shared opcodes, FSM encodings and command-decode helpers for the I2C
// transaction sequencer.
package i2c_pkg;

    localparam logic [2:0] OP_START   = 3'd0;
    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_READ    = 3'd2;
    localparam logic [2:0] OP_RESTART = 3'd3;
    localparam logic [2:0] OP_STOP    = 3'd4;

    typedef enum logic [3:0] {
        IDLE, START, DEV_W, REG, DATA, RSTART, DEV_R, READ, STOP, RESP
    } seq_state_e;

    typedef enum logic {ISSUE, WAIT} seq_phase_e;

    function automatic logic [2:0] op_of(input seq_state_e s);
        case (s)
            START:                    return OP_START;
            DEV_W, REG, DATA, DEV_R:  return OP_WRITE;
            RSTART:                   return OP_RESTART;
            READ:                     return OP_READ;
            STOP:                     return OP_STOP;
            default:                  return OP_START;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input seq_state_e s, input logic [6:0] dev,
                                           input logic [7:0] ra, input logic [7:0] wd);
        case (s)
            DEV_W:   return {dev, 1'b0};
            REG:     return ra;
            DATA:    return wd;
            DEV_R:   return {dev, 1'b1};
            default: return 8'h00;
        endcase
    endfunction

    // Successor on a clean completion; NACK redirection is handled by the caller.
    function automatic seq_state_e next_of(input seq_state_e s, input logic rw);
        case (s)
            START:   return DEV_W;
            DEV_W:   return REG;
            REG:     return rw ? RSTART : DATA;
            DATA:    return STOP;
            RSTART:  return DEV_R;
            DEV_R:   return READ;
            READ:    return STOP;
            default: return RESP;
        endcase
    endfunction

endpackage

// File: rtl/i2c_seq_wdog.sv
// Per-command watchdog: restarts on each command handshake, counts while the
// sequencer waits for completion, and flags the terminal-count cycle.
module i2c_seq_wdog #(
    parameter int LIMIT = 4096
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // First wait cycle sees 0, so the LIMIT-th wait cycle is the terminal one.
    assign o_expire = i_en && (r_cnt == 16'(LIMIT - 1));

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Expands single-byte register read/write requests into START/addr/reg/
// RESTART/data/STOP commands for a byte-level I2C master.
// Optional watchdog abort enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter int OP_W           = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_rw,
    input  logic [6:0]      req_dev_addr,
    input  logic [7:0]      req_reg_addr,
    input  logic [7:0]      req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [7:0]      rsp_rdata,
    output logic            rsp_nack,
    output logic            rsp_timeout,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [OP_W-1:0] cmd_op,
    output logic [7:0]      cmd_byte,
    output logic            cmd_read_nack,
    input  logic            done_valid,
    input  logic            done_ack,
    input  logic [7:0]      done_rdata
);

    if (OP_W < 3 || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("i2c_txn_sequencer: need OP_W >= 3 and TIMEOUT_CYCLES >= 2");
    end

    seq_state_e      r_state;
    seq_phase_e      r_phase;
    logic            r_rw;
    logic [6:0]      r_dev;
    logic [7:0]      r_reg;
    logic [7:0]      r_wdata;
    logic            r_cmd_valid;
    logic [OP_W-1:0] r_cmd_op;
    logic [7:0]      r_cmd_byte;
    logic            r_read_nack;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_rdata;
    logic            r_rsp_nack;

    logic            w_req_ready;
    logic            w_nack;
    seq_state_e      w_next;
    logic            w_timeout;

    assign w_req_ready = (r_state == IDLE) && !r_rsp_valid;
    assign w_nack      = (op_of(r_state) == OP_WRITE) && !done_ack;
    assign w_next      = w_nack ? STOP : next_of(r_state, r_rw);

`ifdef I2C_SEQ_TIMEOUT_EN
    logic w_expire;
    logic r_rsp_timeout;

    i2c_seq_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clr    (r_cmd_valid && cmd_ready),
        .i_en     (r_phase == WAIT),
        .o_expire (w_expire)
    );

    assign w_timeout = w_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_timeout <= 1'b0;
        end else if (r_state == RESP && rsp_ready) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout && !done_valid) begin
            r_rsp_timeout <= 1'b1;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_timeout   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase     <= ISSUE;
            r_rw        <= 1'b0;
            r_dev       <= '0;
            r_reg       <= '0;
            r_wdata     <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= '0;
            r_cmd_byte  <= '0;
            r_read_nack <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_nack  <= 1'b0;
        end else begin
            r_read_nack <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (req_valid && w_req_ready) begin
                        r_rw        <= req_rw;
                        r_dev       <= req_dev_addr;
                        r_reg       <= req_reg_addr;
                        r_wdata     <= req_wdata;
                        r_state     <= START;
                        r_phase     <= ISSUE;
                        r_cmd_valid <= 1'b1;
                        r_cmd_op    <= OP_W'(OP_START);
                        r_cmd_byte  <= 8'h00;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_nack  <= 1'b0;
                    end
                end
                default: begin
                    if (r_phase == ISSUE) begin
                        if (cmd_ready) begin
                            r_phase     <= WAIT;
                            r_cmd_valid <= 1'b0;
                        end
                    end else if (done_valid) begin
                        if (r_state == READ) r_rsp_rdata <= done_rdata;
                        if (w_nack) r_rsp_nack <= 1'b1;
                        r_phase <= ISSUE;
                        r_state <= w_next;
                        if (w_next == RESP) begin
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_op    <= OP_W'(op_of(w_next));
                            r_cmd_byte  <= byte_of(w_next, r_dev, r_reg, r_wdata);
                        end
                    end else if (w_timeout) begin
                        // Bus state is unknown after a hang, so no STOP is attempted.
                        r_state     <= RESP;
                        r_phase     <= ISSUE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                    end
                end
            endcase
        end
    end

    assign req_ready     = w_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_nack      = r_rsp_nack;
    assign cmd_valid     = r_cmd_valid;
    assign cmd_op        = r_cmd_op;
    assign cmd_byte      = r_cmd_byte;
    assign cmd_read_nack = r_read_nack;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a behavioural byte-master model;
// timeout cases run only when I2C_SEQ_TIMEOUT_EN is defined.
module tb_i2c_txn_sequencer;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_dev_addr;
    logic [7:0] req_reg_addr, req_wdata;
    logic       rsp_valid, rsp_ready, rsp_nack, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       cmd_valid, cmd_ready, cmd_read_nack;
    logic [2:0] cmd_op;
    logic [7:0] cmd_byte;
    logic       done_valid, done_ack;
    logic [7:0] done_rdata;

    always #5 clk = ~clk;

    i2c_txn_sequencer #(.OP_W(3), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_byte(cmd_byte), .cmd_read_nack(cmd_read_nack),
        .done_valid(done_valid), .done_ack(done_ack), .done_rdata(done_rdata)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Byte-master model state; trace entry = {read_nack_if_READ, op, byte}.
    int          m_stall, m_nack_idx, m_drop_idx, m_delay_idx, m_delay;
    logic [7:0]  m_rdata;
    logic [11:0] tr [32];
    int          tr_n, pend_idx, pend_wait, stall_cnt, unstable;
    bit          pend;
    logic [2:0]  lat_op;
    logic [7:0]  lat_byte;
    logic [11:0] exp_q[$];

    function automatic logic [11:0] E(input logic rdn, input logic [2:0] op, input logic [7:0] b);
        return {rdn, op, b};
    endfunction

    task automatic clr_master();
        m_stall = 0; m_nack_idx = -1; m_drop_idx = -1; m_delay_idx = -1; m_delay = 0;
        m_rdata = 8'h00; tr_n = 0; pend = 0; pend_idx = 0; pend_wait = 0;
        stall_cnt = 0; unstable = 0; exp_q = {};
    endtask

    initial begin
        cmd_ready = 0; done_valid = 0; done_ack = 0; done_rdata = 0;
        forever begin
            @(negedge clk);
            done_valid = 0; done_ack = 0; done_rdata = 0;
            if (rst) begin
                cmd_ready = 0;
            end else begin
                if (pend) begin
                    if (pend_wait > 0) pend_wait--;
                    else begin
                        done_valid = 1; done_ack = (pend_idx != m_nack_idx);
                        done_rdata = m_rdata; pend = 0;
                    end
                end
                if (cmd_valid) begin
                    if (stall_cnt == 0) begin lat_op = cmd_op; lat_byte = cmd_byte; end
                    else if (cmd_op !== lat_op || cmd_byte !== lat_byte) unstable++;
                    if (stall_cnt < m_stall) begin
                        cmd_ready = 0; stall_cnt++;
                    end else begin
                        cmd_ready = 1; stall_cnt = 0;
                        if (tr_n < 32) tr[tr_n] = {(cmd_op == 3'd2) ? cmd_read_nack : 1'b0, cmd_op, cmd_byte};
                        pend = (tr_n != m_drop_idx); pend_idx = tr_n;
                        pend_wait = (tr_n == m_delay_idx) ? m_delay : 0;
                        tr_n++;
                    end
                end else begin
                    cmd_ready = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
        int t = 0;
        req_rw = rw; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd; req_valid = 1;
        while (!req_ready && t < 50) begin step(); t++; end
        chk("req_ready", 32'(req_ready), 1);
        step();
        // Scramble request fields: only the accept-cycle values may matter.
        req_valid = 0; req_rw = ~rw; req_dev_addr = ~dev; req_reg_addr = ~ra; req_wdata = ~wd;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat = 1;
        while (!rsp_valid && lat < 500) begin step(); lat++; end
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic take_rsp(input int hold);
        int bad = 0;
        logic [9:0] snap;
        snap = {rsp_nack, rsp_timeout, rsp_rdata};
        rsp_ready = 0;
        repeat (hold) begin
            step();
            if (!rsp_valid || req_ready || {rsp_nack, rsp_timeout, rsp_rdata} !== snap) bad++;
        end
        if (hold > 0) chk("rsp_hold", bad, 0);
        rsp_ready = 1; step(); rsp_ready = 0;
        chk("rsp_done_idle", 32'({rsp_valid, req_ready}), 1);
    endtask

    task automatic check_trace(input string tag);
        chk({tag, "_len"}, tr_n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < 32; i++)
            chk($sformatf("%s_cmd%0d", tag, i), 32'(tr[i]), 32'(exp_q[i]));
    endtask

    initial begin
        req_valid = 0; req_rw = 0; req_dev_addr = 0; req_reg_addr = 0; req_wdata = 0;
        rsp_ready = 0;
        clr_master();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_outs", 32'({rsp_rdata, rsp_nack, rsp_timeout, cmd_op, cmd_byte}), 0);
        rst = 0;

        // Zero-wait write
        send(1'b0, 7'h69, 8'h25, 8'h14);
        wait_rsp("wr", 11);
        chk("wr_rsp", 32'({rsp_rdata, rsp_nack, rsp_timeout}), 0);
        exp_q = {E(1'b0, 3'd0, 8'h00), E(1'b0, 3'd1, 8'hD2), E(1'b0, 3'd1, 8'h25),
                 E(1'b0, 3'd1, 8'h14), E(1'b0, 3'd4, 8'h00)};
        check_trace("wr");
        take_rsp(0);

        // Zero-wait read
        clr_master(); m_rdata = 8'h10;
        send(1'b1, 7'h69, 8'h25, 8'h77);
        wait_rsp("rd", 15);
        chk("rd_rdata", 32'(rsp_rdata), 32'h10);
        chk("rd_flags", 32'({rsp_nack, rsp_timeout}), 0);
        exp_q = {E(1'b0, 3'd0, 8'h00), E(1'b0, 3'd1, 8'hD2), E(1'b0, 3'd1, 8'h25),
                 E(1'b0, 3'd3, 8'h00), E(1'b0, 3'd1, 8'hD3), E(1'b1, 3'd2, 8'h00),
                 E(1'b0, 3'd4, 8'h00)};
        check_trace("rd");
        take_rsp(0);

        // Address NACK on a read: skip straight to STOP
        clr_master(); m_nack_idx = 1; m_rdata = 8'hAA;
        send(1'b1, 7'h69, 8'h25, 8'h00);
        wait_rsp("nack", 7);
        chk("nack_flag", 32'(rsp_nack), 1);
        chk("nack_rdata", 32'(rsp_rdata), 0);
        exp_q = {E(1'b0, 3'd0, 8'h00), E(1'b0, 3'd1, 8'hD2), E(1'b0, 3'd4, 8'h00)};
        check_trace("nack");
        take_rsp(0);

        // Back-pressure on every command and on the response
        clr_master(); m_stall = 5;
        send(1'b0, 7'h3C, 8'h81, 8'hF0);
        wait_rsp("stall", 36);
        chk("stall_cmd_stable", unstable, 0);
        exp_q = {E(1'b0, 3'd0, 8'h00), E(1'b0, 3'd1, 8'h78), E(1'b0, 3'd1, 8'h81),
                 E(1'b0, 3'd1, 8'hF0), E(1'b0, 3'd4, 8'h00)};
        check_trace("stall");
        take_rsp(3);

        // Reset while waiting on the READ completion
        clr_master(); m_delay_idx = 5; m_delay = 40; m_rdata = 8'h5A;
        send(1'b1, 7'h11, 8'h22, 8'h00);
        begin
            int t = 0;
            while (tr_n < 6 && t < 100) begin step(); t++; end
        end
        chk("rst_reach_read", tr_n, 6);
        step(); step();
        rst = 1; step(); rst = 0; pend = 0;
        chk("rstmid_cmd_valid", 32'(cmd_valid), 0);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 0);
        chk("rstmid_req_ready", 32'(req_ready), 1);
        step(); step();
        chk("rstmid_no_stop", tr_n, 6);
        clr_master();
        send(1'b0, 7'h12, 8'h34, 8'h56);
        wait_rsp("post_rst", 11);
        chk("post_rst_nack", 32'(rsp_nack), 0);
        exp_q = {E(1'b0, 3'd0, 8'h00), E(1'b0, 3'd1, 8'h24), E(1'b0, 3'd1, 8'h34),
                 E(1'b0, 3'd1, 8'h56), E(1'b0, 3'd4, 8'h00)};
        check_trace("post_rst");
        take_rsp(0);

`ifdef I2C_SEQ_TIMEOUT_EN
        // No completion for the register WRITE: abort after TO wait cycles
        clr_master(); m_drop_idx = 2;
        send(1'b0, 7'h69, 8'h25, 8'h14);
        wait_rsp("tmo", 6 + TO);
        chk("tmo_flag", 32'(rsp_timeout), 1);
        chk("tmo_rdata_nack", 32'({rsp_rdata, rsp_nack}), 0);
        take_rsp(2);
        exp_q = {E(1'b0, 3'd0, 8'h00), E(1'b0, 3'd1, 8'hD2), E(1'b0, 3'd1, 8'h25)};
        check_trace("tmo");

        // Completion lands on the terminal-count cycle: no timeout
        clr_master(); m_delay_idx = 2; m_delay = TO - 1;
        send(1'b0, 7'h69, 8'h25, 8'h14);
        wait_rsp("tmo_edge", 11 + TO - 1);
        chk("tmo_edge_flag", 32'(rsp_timeout), 0);
        chk("tmo_edge_len", tr_n, 5);
        take_rsp(0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
